// File: rtl/ad4003_multich_sequencer_if.sv
// Shared AD4003 bus (CNV/SCK/SDI fan-out, one SDO lane per ADC) plus the per-frame data stream.
`timescale 1ns/1ps
interface ad4003_multich_sequencer_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 18
);
    logic                   cnvst;
    logic                   sck;
    logic                   sdi;
    logic [N_CH-1:0]        adc_sdo;
    logic [N_CH*DATA_W-1:0] data_out;
    logic                   data_valid;

    modport master (output cnvst, sck, sdi, data_out, data_valid, input adc_sdo);
    modport slave  (input cnvst, sck, sdi, data_out, data_valid, output adc_sdo);
endinterface

// File: rtl/ad4003_multich_sequencer.sv
// AD4003 multi-channel sequencer: config write + readback verify, then turbo-mode acquisition.
// seq_state encoding: 0 RESET, 1 CFG_W, 2 CFG_R, 3 ACQ, 4 IDLE.
`timescale 1ns/1ps
module ad4003_multich_sequencer #(
    parameter int          TCQ        = 1,
    parameter int          N_CH       = 4,
    parameter int          DATA_W     = 18,
    parameter int          CYC_LEN    = 80,
    parameter int          CNV_HIGH   = 32,
    parameter int          SAMPLE_DLY = 3,
    parameter logic [15:0] CFG_WORD   = 16'h1402,
    parameter int          CFG_RETRY  = 3
) (
    input  logic                           adc_clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           cfg_req,
    ad4003_multich_sequencer_if.master     bus,
    output logic                           cfg_ok,
    output logic                           cfg_err,
    output logic [31:0]                    sample_cnt,
    output logic [2:0]                     seq_state
);
    localparam int          SCK_START = CNV_HIGH + 2;
    localparam int          WIN_END   = SCK_START + 2 * DATA_W;
    localparam int          CAP_FIRST = SCK_START + 1 + SAMPLE_DLY;
    localparam int          CAP_LAST  = WIN_END - 1 + SAMPLE_DLY;
    localparam int          CW        = $clog2(CYC_LEN);
    localparam int          RW        = $clog2(CFG_RETRY + 1);
    localparam logic [15:0] RD_CMD    = 16'h54FF;

    if (CAP_LAST + 1 >= CYC_LEN) begin : g_chk_timing
        $error("ad4003_multich_sequencer: SCK window plus SAMPLE_DLY does not fit in CYC_LEN");
    end
    if (DATA_W < 16) begin : g_chk_width
        $error("ad4003_multich_sequencer: DATA_W must cover the 16-bit register access");
    end
    if (TCQ < 0 || CFG_RETRY < 1) begin : g_chk_misc
        $error("ad4003_multich_sequencer: TCQ must be >= 0 and CFG_RETRY >= 1");
    end

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_CFG_W = 3'd1,
        S_CFG_R = 3'd2,
        S_ACQ   = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cyc_cntr, cyc_nxt;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic          frame_end, req_pend, cfg_match;
    logic          ok_nxt, err_nxt;
    logic          active_n, win_n, cnvst_d, sck_d, sdi_d;
    logic          cap_hit, last_cap;
    logic [15:0]   sdi_word;
    int            pos_n, off_n, pos_c, off_c;

    logic [N_CH-1:0][DATA_W-2:0] shreg, shreg_nxt;
    logic [N_CH*DATA_W-1:0]      word_flat;
    logic [N_CH-1:0]             lane_ok;

    assign frame_end = (cyc_cntr == CW'(CYC_LEN - 1));
    assign cyc_nxt   = frame_end ? '0 : cyc_cntr + 1'b1;
    assign seq_state = state;

    // Outputs are computed from the next counter/state so the registered pins line up with cyc_cntr.
    assign pos_n    = int'(cyc_nxt);
    assign off_n    = pos_n - SCK_START;
    // RESET is held quiet for its frame; the bus only runs once configuration starts.
    assign active_n = (state_nxt == S_CFG_W) || (state_nxt == S_CFG_R) || (state_nxt == S_ACQ);
    assign win_n    = active_n && (pos_n >= SCK_START) && (pos_n < WIN_END);
    assign sdi_word = (state_nxt == S_CFG_W) ? CFG_WORD : RD_CMD;

    assign pos_c    = int'(cyc_cntr);
    assign off_c    = pos_c - CAP_FIRST;
    assign cap_hit  = (pos_c >= CAP_FIRST) && (pos_c <= CAP_LAST) && !off_c[0];
    assign last_cap = (pos_c == CAP_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        logic [DATA_W-1:0] word;
        assign word         = {shreg[i], bus.adc_sdo[i]};
        assign shreg_nxt[i] = word[DATA_W-2:0];
        assign word_flat[i*DATA_W +: DATA_W] = word;
        // Register contents come back in the eight SCK periods following the read command byte.
        assign lane_ok[i]   = (word[DATA_W-9 -: 8] == CFG_WORD[7:0]);
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        ok_nxt    = cfg_ok;
        err_nxt   = cfg_err;
        if (frame_end) begin
            if (req_pend || cfg_req) begin
                state_nxt = S_CFG_W;
                retry_nxt = '0;
                ok_nxt    = 1'b0;
                err_nxt   = 1'b0;
            end else begin
                case (state)
                    S_RESET: state_nxt = S_CFG_W;
                    S_CFG_W: state_nxt = S_CFG_R;
                    S_CFG_R: begin
                        if (cfg_match) begin
                            ok_nxt    = 1'b1;
                            retry_nxt = '0;
                            state_nxt = enable ? S_ACQ : S_IDLE;
                        end else if (retry_cnt == RW'(CFG_RETRY - 1)) begin
                            err_nxt   = 1'b1;
                            retry_nxt = '0;
                            state_nxt = S_IDLE;
                        end else begin
                            retry_nxt = retry_cnt + 1'b1;
                            state_nxt = S_CFG_W;
                        end
                    end
                    S_ACQ:   if (!enable) state_nxt = S_IDLE;
                    S_IDLE:  if (enable && cfg_ok) state_nxt = S_ACQ;
                    default: state_nxt = S_RESET;
                endcase
            end
        end
    end

    always_comb begin
        cnvst_d = 1'b0;
        sck_d   = 1'b0;
        sdi_d   = 1'b1;
        if (active_n && pos_n < CNV_HIGH) cnvst_d = 1'b1;
        if (win_n) begin
            sck_d = off_n[0];
            if (state_nxt != S_ACQ && (off_n >>> 1) < 16)
                sdi_d = sdi_word[4'(15 - (off_n >>> 1))];
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            state     <= S_RESET;
            cyc_cntr  <= '0;
            retry_cnt <= '0;
            cfg_ok    <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cyc_cntr  <= cyc_nxt;
            retry_cnt <= retry_nxt;
            cfg_ok    <= ok_nxt;
            cfg_err   <= err_nxt;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            req_pend       <= 1'b0;
            cfg_match      <= 1'b0;
            shreg          <= '0;
            bus.cnvst      <= 1'b0;
            bus.sck        <= 1'b0;
            bus.sdi        <= 1'b1;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            sample_cnt     <= '0;
        end else begin
            req_pend       <= frame_end ? 1'b0 : (req_pend | cfg_req);
            bus.cnvst      <= cnvst_d;
            bus.sck        <= sck_d;
            bus.sdi        <= sdi_d;
            bus.data_valid <= last_cap && (state == S_ACQ);
            if (cap_hit) shreg <= shreg_nxt;
            if (last_cap && state == S_ACQ) begin
                bus.data_out <= word_flat;
                sample_cnt   <= sample_cnt + 32'd1;
            end
            if (last_cap && state == S_CFG_R) cfg_match <= &lane_ok;
        end
    end
endmodule

// File: tb/tb_ad4003_multich_sequencer.sv
// Randomized bench for ad4003_multich_sequencer: frame-level reference model plus an SDO lane BFM.
`timescale 1ns/1ps
module tb_ad4003_multich_sequencer;
    localparam int          N_CH       = 4;
    localparam int          DATA_W     = 18;
    localparam int          CYC_LEN    = 80;
    localparam int          CNV_HIGH   = 32;
    localparam int          SAMPLE_DLY = 3;
    localparam logic [15:0] CFG_WORD   = 16'h1402;
    localparam logic [7:0]  CFG_DATA   = 8'h02;
    localparam logic [15:0] RD_CMD     = 16'h54FF;
    localparam int          CFG_RETRY  = 3;
    localparam int          SCK_START  = CNV_HIGH + 2;
    localparam int          VALID_AT   = SCK_START + 2 * DATA_W + SAMPLE_DLY;
    localparam int          IW         = $clog2(DATA_W);

    typedef enum {M_RST, M_CW, M_CR, M_ACQ, M_IDLE} mmode_t;

    logic        adc_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_ok, cfg_err;
    logic [31:0] sample_cnt;
    logic [2:0]  seq_state;

    ad4003_multich_sequencer_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    ad4003_multich_sequencer #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CYC_LEN(CYC_LEN), .CNV_HIGH(CNV_HIGH),
        .SAMPLE_DLY(SAMPLE_DLY), .CFG_WORD(CFG_WORD), .CFG_RETRY(CFG_RETRY)
    ) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .enable(enable), .cfg_req(cfg_req), .bus(bus),
        .cfg_ok(cfg_ok), .cfg_err(cfg_err), .sample_cnt(sample_cnt), .seq_state(seq_state)
    );

    always #3 adc_clk = ~adc_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model, tracked per frame
    mmode_t            m_mode = M_RST;
    int                m_pos = 0, m_fails = 0;
    bit                m_pend = 0, m_ok = 0, m_err = 0;
    logic [31:0]       m_sc = '0;
    logic [DATA_W-1:0] m_data [N_CH];
    logic [DATA_W-1:0] tx [N_CH];
    logic [DATA_W-1:0] pat [N_CH];
    bit                bfm_bad = 0, pat_mode = 0;
    int                rises = 0;
    logic              sck_prev = 1'b0;
    logic [N_CH-1:0]   pin = '0;
    logic [N_CH-1:0]   hist [SAMPLE_DLY];
    logic [2:0]        st_prev = '0;

    function automatic bit echo_ok();
        for (int i = 0; i < N_CH; i++)
            if (tx[i][DATA_W-9 -: 8] !== CFG_DATA) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = M_RST; m_pos = 0; m_pend = 0; m_ok = 0; m_err = 0; m_fails = 0; m_sc = '0;
            for (int i = 0; i < N_CH; i++) m_data[i] = '0;
        end else if (m_pos == CYC_LEN - 1) begin
            m_pos = 0;
            if (m_pend || cfg_req) begin
                m_mode = M_CW; m_ok = 0; m_err = 0; m_fails = 0;
            end else if (m_mode == M_RST) m_mode = M_CW;
            else if (m_mode == M_CW) m_mode = M_CR;
            else if (m_mode == M_CR) begin
                if (echo_ok()) begin
                    m_ok = 1; m_fails = 0; m_mode = enable ? M_ACQ : M_IDLE;
                end else if (m_fails + 1 >= CFG_RETRY) begin
                    m_err = 1; m_fails = 0; m_mode = M_IDLE;
                end else begin
                    m_fails++; m_mode = M_CW;
                end
            end else if (m_mode == M_ACQ) begin
                if (!enable) m_mode = M_IDLE;
            end else if (enable && m_ok) m_mode = M_ACQ;
            m_pend = 0;
        end else begin
            m_pos++;
            m_pend = m_pend || cfg_req;
        end
    endtask

    task automatic step();
        bit act, win, e_cnv, e_sck, e_sdi, e_vld;
        int off;
        logic [15:0] w;
        @(posedge adc_clk);
        model_edge();
        #1;
        if (m_pos == 0) begin
            rises = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (m_mode == M_CR) begin
                    tx[i] = DATA_W'($urandom);
                    tx[i][DATA_W-9 -: 8] = bfm_bad ? 8'h00 : CFG_DATA;
                end else if (pat_mode) tx[i] = pat[i];
                else tx[i] = DATA_W'($urandom);
            end
        end
        // Lane BFM: next bit leaves the ADC on each SCK rise, seen by the fabric SAMPLE_DLY-1 cycles later
        if (bus.sck && !sck_prev) begin
            if (rises < DATA_W)
                for (int i = 0; i < N_CH; i++) pin[i] = tx[i][IW'(DATA_W - 1 - rises)];
            rises++;
        end
        sck_prev = bus.sck;
        for (int j = SAMPLE_DLY - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pin;
        bus.adc_sdo = hist[SAMPLE_DLY-1];

        act   = (m_mode == M_CW) || (m_mode == M_CR) || (m_mode == M_ACQ);
        off   = m_pos - SCK_START;
        win   = act && m_pos >= SCK_START && m_pos < SCK_START + 2 * DATA_W;
        e_cnv = act && m_pos < CNV_HIGH;
        e_sck = win && (off % 2 == 1);
        w     = (m_mode == M_CW) ? CFG_WORD : RD_CMD;
        e_sdi = 1'b1;
        if (win && m_mode != M_ACQ && off / 2 < 16) e_sdi = w[4'(15 - off / 2)];
        e_vld = (m_mode == M_ACQ) && (m_pos == VALID_AT);
        if (e_vld) begin
            for (int i = 0; i < N_CH; i++) m_data[i] = tx[i];
            m_sc++;
        end
        chk("cnvst", bus.cnvst, e_cnv);
        chk("sck", bus.sck, e_sck);
        chk("sdi", bus.sdi, e_sdi);
        chk("data_valid", bus.data_valid, e_vld);
        chk("cfg_ok", cfg_ok, m_ok);
        chk("cfg_err", cfg_err, m_err);
        chk("sample_cnt", sample_cnt, m_sc);
        if (e_vld || m_pos == 0)
            for (int i = 0; i < N_CH; i++)
                chk($sformatf("data_out_lane%0d", i), bus.data_out[i*DATA_W +: DATA_W], m_data[i]);
        if (m_pos == CYC_LEN - 1) chk("sck_rises", rises, act ? DATA_W : 0);
        if (m_pos != 0) chk("seq_state_stable", seq_state, st_prev);
        st_prev = seq_state;
    endtask

    task automatic frames(input int n);
        repeat (n * CYC_LEN) step();
    endtask

    task automatic goto_pos(input int p);
        for (int g = 0; g <= CYC_LEN && m_pos != p; g++) step();
        if (m_pos != p) chk("goto_pos", m_pos, p);
    endtask

    task automatic pulse_req();
        cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
    endtask

    initial begin
        pat[0] = 18'h2A5A5; pat[1] = 18'h15A5A; pat[2] = 18'h3FFFF; pat[3] = 18'h00001;
        for (int j = 0; j < SAMPLE_DLY; j++) hist[j] = '0;
        for (int i = 0; i < N_CH; i++) begin m_data[i] = '0; tx[i] = '0; end
        bus.adc_sdo = '0;
        repeat (3) step();
        // Reset release, config echoed, acquisition
        rst_n = 1'b1; enable = 1'b1;
        frames(6);
        chk("t1_cfg_ok", cfg_ok, 1'b1);
        // Fixed lane patterns
        pat_mode = 1; frames(2); pat_mode = 0;
        // enable dropped mid-frame, then restored
        goto_pos(40); enable = 1'b0;
        goto_pos(10); enable = 1'b1;
        frames(2);
        // Readback never matches: retries exhausted
        bfm_bad = 1; pulse_req();
        frames(9);
        chk("t3_cfg_err", cfg_err, 1'b1);
        bfm_bad = 0; pulse_req();
        frames(4);
        // Reset in the middle of an acquisition frame
        goto_pos(50); rst_n = 1'b0; step(); rst_n = 1'b1;
        frames(5);
        // sample_cnt wrap, then cfg_req beats enable=0 at the same boundary
        goto_pos(5);
        force dut.sample_cnt = 32'hFFFF_FFFE;
        m_sc = 32'hFFFF_FFFE;
        step();
        release dut.sample_cnt;
        frames(2);
        chk("t6_wrap", sample_cnt, 32'd0);
        goto_pos(60); enable = 1'b0; pulse_req();
        goto_pos(1);
        chk("t6_cfgw_cnvst", bus.cnvst, 1'b1);
        enable = 1'b1;
        frames(3);
        // Random enable / cfg_req / readback-fault traffic
        for (int f = 0; f < 12; f++) begin
            goto_pos($urandom_range(1, CYC_LEN - 2));
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bfm_bad = !bfm_bad;
            if ($urandom_range(0, 5) == 0) pulse_req();
            goto_pos(0);
        end
        bfm_bad = 0; enable = 1'b1; pulse_req();
        frames(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
